// File: rtl/matrix_stream_loader_pkg.sv
// Shared types and constants for the matrix stream loader.
// Holds state encodings, the frame-count width and sizing helpers.
package matrix_stream_loader_pkg;

    localparam int FRAMES_W = 16;

    typedef enum logic [2:0] {
        LOADER_LOAD_A    = 3'd0,
        LOADER_LOAD_B    = 3'd1,
        LOADER_CHK       = 3'd2,
        LOADER_START     = 3'd3,
        LOADER_WAIT_DONE = 3'd4
    } loader_state_e;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/matrix_stream_loader_if.sv
// Stream-in, A/B write-port and accelerator handshake bundle.
// master = loader side, slave = source/memory/accelerator side.
interface matrix_stream_loader_if
    import matrix_stream_loader_pkg::*;
#(
    parameter int DW  = 8,
    parameter int AAW = 4,
    parameter int BAW = 4
);
    logic [DW-1:0]       s_data;
    logic                s_valid;
    logic                s_ready;
    logic                flush;
    logic [DW-1:0]       a_data_out;
    logic [AAW-1:0]      a_addr;
    logic                a_wen;
    logic [DW-1:0]       b_data_out;
    logic [BAW-1:0]      b_addr;
    logic                b_wen;
    logic                start_computation;
    logic                computation_done;
    logic                busy;
    logic                frame_error;
    logic [FRAMES_W-1:0] frames_done;

    modport master (
        input  s_data, s_valid, flush, computation_done,
        output s_ready, a_data_out, a_addr, a_wen,
        output b_data_out, b_addr, b_wen,
        output start_computation, busy, frame_error, frames_done
    );

    modport slave (
        output s_data, s_valid, flush, computation_done,
        input  s_ready, a_data_out, a_addr, a_wen,
        input  b_data_out, b_addr, b_wen,
        input  start_computation, busy, frame_error, frames_done
    );

endinterface

// File: rtl/matrix_stream_loader_checksum.sv
// Running mod-2^DW sum of frame elements with clear and compare.
module loader_checksum #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          add_i,
    input  logic [DW-1:0] data_i,
    input  logic [DW-1:0] cmp_i,
    output logic          match_o
);
    logic [DW-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i)      sum_d = '0;
        else if (add_i) sum_d = sum_q + data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign match_o = (sum_q == cmp_i);

endmodule

// File: rtl/matrix_stream_loader.sv
// Unpacks a word stream into A then B write ports, starts the accelerator
// and waits (watchdog-bounded) for done. MATRIX_LOADER_CHECKSUM_EN adds a trailer check.
module matrix_stream_loader
    import matrix_stream_loader_pkg::*;
#(
    parameter int M              = 3,
    parameter int N              = 3,
    parameter int P              = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                    clk,
    input logic                    rst_n,
    matrix_stream_loader_if.master bus
);
    localparam int A_WORDS = M * N;
    localparam int B_WORDS = N * P;
    localparam int AW = cnt_w(A_WORDS);
    localparam int BW = cnt_w(B_WORDS);
    localparam int IW = cnt_w(max2(A_WORDS, B_WORDS));
    localparam int WW = cnt_w(TIMEOUT_CYCLES);

    loader_state_e         state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [WW-1:0]         wd_q, wd_d;
    logic [AW-1:0]         a_addr_q, a_addr_d;
    logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
    logic                  a_wen_q, a_wen_d;
    logic [BW-1:0]         b_addr_q, b_addr_d;
    logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
    logic                  b_wen_q, b_wen_d;
    logic                  start_q, start_d;
    logic                  err_q, err_d;
    logic [FRAMES_W-1:0]   frames_q, frames_d;
    logic                  s_ready;
    logic                  beat;

`ifdef MATRIX_LOADER_CHECKSUM_EN
    logic ck_clr, ck_add, ck_match;

    loader_checksum #(.DW(DATA_WIDTH)) u_checksum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (ck_clr),
        .add_i   (ck_add),
        .data_i  (bus.s_data),
        .cmp_i   (bus.s_data),
        .match_o (ck_match)
    );
`endif

    assign s_ready = (state_q == LOADER_LOAD_A)
                  || (state_q == LOADER_LOAD_B)
                  || (state_q == LOADER_CHK);
    assign beat = bus.s_valid && s_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wd_d     = wd_q;
        a_addr_d = a_addr_q;
        a_data_d = a_data_q;
        a_wen_d  = 1'b0;
        b_addr_d = b_addr_q;
        b_data_d = b_data_q;
        b_wen_d  = 1'b0;
        start_d  = 1'b0;
        err_d    = 1'b0;
        frames_d = frames_q;
`ifdef MATRIX_LOADER_CHECKSUM_EN
        ck_clr   = 1'b0;
        ck_add   = 1'b0;
`endif
        unique case (state_q)
            LOADER_LOAD_A: if (beat) begin
                a_wen_d  = 1'b1;
                a_addr_d = AW'(idx_q);
                a_data_d = bus.s_data;
`ifdef MATRIX_LOADER_CHECKSUM_EN
                ck_add   = 1'b1;
`endif
                if (idx_q == IW'(A_WORDS - 1)) begin
                    state_d = LOADER_LOAD_B;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            LOADER_LOAD_B: if (beat) begin
                b_wen_d  = 1'b1;
                b_addr_d = BW'(idx_q);
                b_data_d = bus.s_data;
`ifdef MATRIX_LOADER_CHECKSUM_EN
                ck_add   = 1'b1;
`endif
                if (idx_q == IW'(B_WORDS - 1)) begin
                    idx_d = '0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
                    state_d = LOADER_CHK;
`else
                    state_d = LOADER_START;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            LOADER_CHK: begin
`ifdef MATRIX_LOADER_CHECKSUM_EN
                if (beat) begin
                    if (ck_match) begin
                        state_d = LOADER_START;
                    end else begin
                        err_d   = 1'b1;
                        state_d = LOADER_LOAD_A;
                        ck_clr  = 1'b1;
                    end
                end
`else
                state_d = LOADER_LOAD_A;
`endif
            end
            LOADER_START: begin
                start_d = 1'b1;
                wd_d    = '0;
                state_d = LOADER_WAIT_DONE;
            end
            LOADER_WAIT_DONE: begin
                // done beats a timeout landing in the same cycle
                if (bus.computation_done) begin
                    frames_d = frames_q + FRAMES_W'(1);
                    state_d  = LOADER_LOAD_A;
`ifdef MATRIX_LOADER_CHECKSUM_EN
                    ck_clr   = 1'b1;
`endif
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = LOADER_LOAD_A;
`ifdef MATRIX_LOADER_CHECKSUM_EN
                    ck_clr  = 1'b1;
`endif
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = LOADER_LOAD_A;
                idx_d   = '0;
            end
        endcase

        if (bus.flush) begin
            state_d  = LOADER_LOAD_A;
            idx_d    = '0;
            wd_d     = wd_q;
            a_addr_d = a_addr_q;
            a_data_d = a_data_q;
            a_wen_d  = 1'b0;
            b_addr_d = b_addr_q;
            b_data_d = b_data_q;
            b_wen_d  = 1'b0;
            start_d  = 1'b0;
            err_d    = 1'b0;
            frames_d = frames_q;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            ck_clr   = 1'b1;
            ck_add   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOADER_LOAD_A;
            idx_q    <= '0;
            wd_q     <= '0;
            a_addr_q <= '0;
            a_data_q <= '0;
            a_wen_q  <= 1'b0;
            b_addr_q <= '0;
            b_data_q <= '0;
            b_wen_q  <= 1'b0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wd_q     <= wd_d;
            a_addr_q <= a_addr_d;
            a_data_q <= a_data_d;
            a_wen_q  <= a_wen_d;
            b_addr_q <= b_addr_d;
            b_data_q <= b_data_d;
            b_wen_q  <= b_wen_d;
            start_q  <= start_d;
            err_q    <= err_d;
            frames_q <= frames_d;
        end
    end

    assign bus.s_ready           = s_ready;
    assign bus.a_addr            = a_addr_q;
    assign bus.a_data_out        = a_data_q;
    assign bus.a_wen             = a_wen_q;
    assign bus.b_addr            = b_addr_q;
    assign bus.b_data_out        = b_data_q;
    assign bus.b_wen             = b_wen_q;
    assign bus.start_computation = start_q;
    assign bus.frame_error       = err_q;
    assign bus.frames_done       = frames_q;
    assign bus.busy = !((state_q == LOADER_LOAD_A) && (idx_q == '0));

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Randomized self-checking bench for matrix_stream_loader (M=N=P=3, 8-bit).
// Exercises the trailer check too when MATRIX_LOADER_CHECKSUM_EN is defined.
module tb_matrix_stream_loader;

    localparam int TO = 16;

    typedef struct {
        int addr;
        int data;
        int c;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    matrix_stream_loader_if #(.DW(8), .AAW(4), .BAW(4)) bus ();

    matrix_stream_loader #(
        .M(3), .N(3), .P(3), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int exp_frames = 0;
    logic [7:0] fr [18];
    wr_t aq [$];
    wr_t bq [$];
    int starts [$];
    int errs [$];
    int acc [$];
    wr_t mt;

    always @(posedge clk) cyc <= cyc + 1;

    // event log sampled mid-cycle
    always @(negedge clk) begin
        if (bus.a_wen) begin
            mt.addr = int'(bus.a_addr);
            mt.data = int'(bus.a_data_out);
            mt.c = cyc;
            aq.push_back(mt);
        end
        if (bus.b_wen) begin
            mt.addr = int'(bus.b_addr);
            mt.data = int'(bus.b_data_out);
            mt.c = cyc;
            bq.push_back(mt);
        end
        if (bus.start_computation) starts.push_back(cyc);
        if (bus.frame_error) errs.push_back(cyc);
    end

    task automatic clr_mon();
        aq.delete(); bq.delete(); starts.delete(); errs.delete(); acc.delete();
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic put(input logic [7:0] w);
        int n;
        n = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data = w;
        while (!bus.s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) begin
            vectors++; miscompares++;
            $display("FAIL put_ready got s_ready=0 want 1");
        end else begin
            acc.push_back(cyc);
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
    endtask

    function automatic logic [7:0] fsum();
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < 18; i++) s = s + fr[i];
        return s;
    endfunction

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < 18; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            put(fr[i]);
        end
`ifdef MATRIX_LOADER_CHECKSUM_EN
        put(fsum());
`endif
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (starts.size() == 0 && n < 60) begin tick(); n++; end
    endtask

    task automatic wait_err();
        int n;
        n = 0;
        while (errs.size() == 0 && n < 60) begin tick(); n++; end
    endtask

    task automatic give_done();
        @(negedge clk); bus.computation_done = 1'b1;
        @(negedge clk); bus.computation_done = 1'b0;
        #1;
    endtask

    task automatic test_reset(input bit mid);
        if (mid) begin
            clr_mon();
            for (int i = 0; i < 18; i++) fr[i] = 8'($urandom);
            send_frame(0);
            wait_start();
        end
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        exp_frames = 0;
        vectors++;
        if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_busy got %b%b want 10", bus.s_ready, bus.busy);
        end
        vectors++;
        if ({bus.a_wen, bus.b_wen, bus.start_computation, bus.frame_error} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_pulses got %b want 0000",
                     {bus.a_wen, bus.b_wen, bus.start_computation, bus.frame_error});
        end
        vectors++;
        if (bus.frames_done !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_frames got %0d want 0", bus.frames_done);
        end
        vectors++;
        if ({bus.a_addr, bus.b_addr, bus.a_data_out, bus.b_data_out} !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_addr_data got %h want 0",
                     {bus.a_addr, bus.b_addr, bus.a_data_out, bus.b_data_out});
        end
        @(posedge clk); #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream(input bit gaps);
        clr_mon();
        for (int i = 0; i < 18; i++) fr[i] = gaps ? 8'($urandom) : 8'(i + 1);
        send_frame(gaps);
        wait_start();
        vectors++;
        if (aq.size() != 9 || bq.size() != 9) begin
            miscompares++;
            $display("FAIL stream_count got a=%0d b=%0d want 9 9", aq.size(), bq.size());
        end
        for (int k = 0; k < 9 && k < aq.size() && 9 + k < acc.size(); k++) begin
            vectors++;
            if (aq[k].addr != k || aq[k].data != int'(fr[k]) || aq[k].c != acc[k] + 1) begin
                miscompares++;
                $display("FAIL a_write[%0d] got addr=%0d data=%0d cyc=%0d want %0d %0d %0d",
                         k, aq[k].addr, aq[k].data, aq[k].c, k, fr[k], acc[k] + 1);
            end
        end
        for (int k = 0; k < 9 && k < bq.size() && 9 + k < acc.size(); k++) begin
            vectors++;
            if (bq[k].addr != k || bq[k].data != int'(fr[9 + k]) || bq[k].c != acc[9 + k] + 1) begin
                miscompares++;
                $display("FAIL b_write[%0d] got addr=%0d data=%0d cyc=%0d want %0d %0d %0d",
                         k, bq[k].addr, bq[k].data, bq[k].c, k, fr[9 + k], acc[9 + k] + 1);
            end
        end
        vectors++;
        if (starts.size() != 1 || acc.size() == 0 || bq.size() != 9) begin
            miscompares++;
            $display("FAIL start_count got %0d want 1", starts.size());
        end else begin
            vectors++;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            if (starts[0] != acc[acc.size() - 1] + 2) begin
`else
            if (starts[0] != bq[8].c + 1) begin
`endif
                miscompares++;
                $display("FAIL start_time got cyc=%0d last_b_wen=%0d", starts[0], bq[8].c);
            end
        end
        vectors++;
        if (bus.busy !== 1'b1 || bus.s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_busy got busy=%b rdy=%b want 1 0", bus.busy, bus.s_ready);
        end
        give_done();
        exp_frames++;
        vectors++;
        if (int'(bus.frames_done) != exp_frames || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL frames_after_done got %0d busy=%b want %0d busy=0",
                     bus.frames_done, bus.busy, exp_frames);
        end
    endtask

    task automatic test_back_to_back();
        int dcyc;
        clr_mon();
        for (int i = 0; i < 18; i++) fr[i] = 8'($urandom);
        send_frame(0);
        wait_start();
        for (int i = 0; i < 18; i++) fr[i] = 8'($urandom);
        @(negedge clk);
        bus.computation_done = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data = fr[0];
        dcyc = cyc;
        @(posedge clk); #1;
        bus.computation_done = 1'b0;
        exp_frames++;
        clr_mon();
        send_frame(0);
        wait_start();
        vectors++;
        if (acc.size() == 0 || aq.size() == 0) begin
            miscompares++;
            $display("FAIL b2b_no_beat got acc=%0d wen=%0d want >0", acc.size(), aq.size());
        end else if (acc[0] != dcyc + 1 || aq[0].c != dcyc + 2
                     || aq[0].addr != 0 || aq[0].data != int'(fr[0])) begin
            miscompares++;
            $display("FAIL b2b_first got acc=%0d wen=%0d addr=%0d data=%0d want %0d %0d 0 %0d",
                     acc[0], aq[0].c, aq[0].addr, aq[0].data, dcyc + 1, dcyc + 2, fr[0]);
        end
        give_done();
        exp_frames++;
        vectors++;
        if (int'(bus.frames_done) != exp_frames || starts.size() != 1) begin
            miscompares++;
            $display("FAIL b2b_frames got %0d starts=%0d want %0d 1",
                     bus.frames_done, starts.size(), exp_frames);
        end
    endtask

    task automatic test_flush();
        logic [7:0] pre [5];
        clr_mon();
        for (int i = 0; i < 5; i++) begin
            pre[i] = 8'($urandom);
            put(pre[i]);
        end
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data = 8'h5A;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.s_valid = 1'b0;
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.a_wen !== 1'b0 || aq.size() != 5) begin
            miscompares++;
            $display("FAIL flush_idle got busy=%b wen=%b writes=%0d want 0 0 5",
                     bus.busy, bus.a_wen, aq.size());
        end
        acc.delete();
        for (int i = 0; i < 18; i++) fr[i] = 8'(i + 1);
        send_frame(0);
        wait_start();
        repeat (3) tick();
        vectors++;
        if (aq.size() != 14 || bq.size() != 9 || starts.size() != 1) begin
            miscompares++;
            $display("FAIL flush_counts got a=%0d b=%0d st=%0d want 14 9 1",
                     aq.size(), bq.size(), starts.size());
        end else begin
            for (int k = 0; k < 14; k++) begin
                vectors++;
                if (aq[k].addr != (k < 5 ? k : k - 5)
                    || aq[k].data != (k < 5 ? int'(pre[k]) : int'(fr[k - 5]))) begin
                    miscompares++;
                    $display("FAIL flush_a[%0d] got addr=%0d data=%0d", k, aq[k].addr, aq[k].data);
                end
            end
        end
        give_done();
        exp_frames++;
        vectors++;
        if (int'(bus.frames_done) != exp_frames) begin
            miscompares++;
            $display("FAIL flush_frames got %0d want %0d", bus.frames_done, exp_frames);
        end
    endtask

    task automatic test_timeout();
        clr_mon();
        give_done();
        vectors++;
        if (int'(bus.frames_done) != exp_frames || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_done got %0d want %0d", bus.frames_done, exp_frames);
        end
        for (int i = 0; i < 18; i++) fr[i] = 8'($urandom);
        send_frame(0);
        wait_start();
        wait_err();
        tick();
        vectors++;
        if (errs.size() != 1 || starts.size() != 1) begin
            miscompares++;
            $display("FAIL timeout_count got err=%0d st=%0d want 1 1", errs.size(), starts.size());
        end else begin
            vectors++;
            if (errs[0] != starts[0] + TO) begin
                miscompares++;
                $display("FAIL timeout_time got %0d want %0d", errs[0] - starts[0], TO);
            end
        end
        vectors++;
        if (int'(bus.frames_done) != exp_frames || bus.busy !== 1'b0 || bus.s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_state got frames=%0d busy=%b rdy=%b want %0d 0 1",
                     bus.frames_done, bus.busy, bus.s_ready, exp_frames);
        end
    endtask

`ifdef MATRIX_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clr_mon();
        for (int i = 0; i < 18; i++) fr[i] = 8'(i + 1);
        for (int i = 0; i < 18; i++) put(fr[i]);
        put(8'hAB);
        wait_start();
        vectors++;
        if (starts.size() != 1 || errs.size() != 0 || acc.size() != 19) begin
            miscompares++;
            $display("FAIL ck_good got st=%0d err=%0d want 1 0", starts.size(), errs.size());
        end else if (starts[0] != acc[18] + 2) begin
            vectors++;
            miscompares++;
            $display("FAIL ck_good_time got %0d want %0d", starts[0], acc[18] + 2);
        end
        give_done();
        exp_frames++;
        clr_mon();
        for (int i = 0; i < 18; i++) put(fr[i]);
        put(8'h00);
        wait_err();
        repeat (4) tick();
        vectors++;
        if (errs.size() != 1 || starts.size() != 0 || acc.size() != 19) begin
            miscompares++;
            $display("FAIL ck_bad got err=%0d st=%0d want 1 0", errs.size(), starts.size());
        end else if (errs[0] != acc[18] + 1) begin
            vectors++;
            miscompares++;
            $display("FAIL ck_bad_time got %0d want %0d", errs[0], acc[18] + 1);
        end
        vectors++;
        if (int'(bus.frames_done) != exp_frames || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ck_bad_state got %0d want %0d", bus.frames_done, exp_frames);
        end
    endtask
`endif

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = 8'd0;
        bus.flush = 1'b0;
        bus.computation_done = 1'b0;
        test_reset(0);
        test_stream(0);
        test_stream(1);
        test_stream(1);
        test_reset(1);
        test_back_to_back();
        test_flush();
        test_timeout();
`ifdef MATRIX_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
